// File: rtl/sky_pkg.sv
// sky_pkg: shared definitions for the stacking game.
//   - sky_state_e : game engine state encoding
//   - sky_clr_e   : 2-bit block colour codes (also decoded by the draw stage)
//   - DEF_*       : default geometry constants shared with the draw stage
//   - LFSR seed/taps and a single-step helper for the block generator
package sky_pkg;

  typedef enum logic [2:0] {
    ST_SPAWN,
    ST_FALL,
    ST_LAND,
    ST_OVER,
    ST_FULL
  } sky_state_e;

  typedef enum logic [1:0] {
    CLR_NONE  = 2'b00,
    CLR_GREEN = 2'b01,
    CLR_BLUE  = 2'b10,
    CLR_RED   = 2'b11
  } sky_clr_e;

  localparam int unsigned DEF_WIDTH        = 100;
  localparam int unsigned DEF_HEIGHT_RATIO = 20;
  localparam int unsigned DEF_BASE_Y       = 400;
  localparam int unsigned DEF_SCREEN_W     = 640;

  // Galois form of x^16+x^14+x^13+x^11+1, shifting right.
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_advance(input logic [15:0] cur);
    return {1'b0, cur[15:1]} ^ (cur[0] ? LFSR_TAPS : '0);
  endfunction

endpackage

// File: rtl/sky_lfsr.sv
// sky_lfsr: free-running 16-bit Galois LFSR, advances every clock.
// Ports:
//   clk_i   : clock
//   rst_ni  : asynchronous active-low reset (loads LFSR_SEED)
//   rnd_o   : low 12 bits of the current LFSR state
module sky_lfsr
  import sky_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  output logic [11:0] rnd_o
);

  logic [15:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_advance(lfsr_q);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) lfsr_q <= LFSR_SEED;
    else         lfsr_q <= lfsr_d;
  end

  assign rnd_o = lfsr_q[11:0];

endmodule

// File: rtl/block_drop_ctrl.sv
// block_drop_ctrl: game-state engine for the stacking game. Spawns
// pseudo-random blocks, drops them once per frame, resolves catch/miss
// against the player stack and tracks height, misses and end-of-game.
// Optional feature macro: SKY_SPEEDUP_EN (fall speed grows with height).
// Ports:
//   dclk              : pixel clock
//   rst               : asynchronous active-low reset
//   tick              : one-cycle frame strobe (start of vertical blank)
//   move_l, move_r    : level-sensitive player buttons
//   start             : one-cycle restart pulse
//   pos_x             : stack left x
//   colors            : 16 x 2-bit stack slots, slot i at [2i+1:2i]
//   fall_x, fall_y    : falling block top-left corner
//   fall_clr          : falling block colour, 00 = nothing drawn
//   height            : occupied slots (0..16)
//   game_over, win    : sticky end-of-game flags
module block_drop_ctrl
  import sky_pkg::*;
#(
  parameter int unsigned WIDTH        = DEF_WIDTH,
  parameter int unsigned HEIGHT_RATIO = DEF_HEIGHT_RATIO,
  parameter int unsigned BASE_Y       = DEF_BASE_Y,
  parameter int unsigned SCREEN_W     = DEF_SCREEN_W,
  parameter int unsigned MOVE_STEP    = 4,
  parameter int unsigned FALL_STEP    = 2,
  parameter int unsigned MAX_MISS     = 3
) (
  input  logic        dclk,
  input  logic        rst,
  input  logic        tick,
  input  logic        move_l,
  input  logic        move_r,
  input  logic        start,
  output logic [9:0]  pos_x,
  output logic [31:0] colors,
  output logic [9:0]  fall_x,
  output logic [9:0]  fall_y,
  output logic [1:0]  fall_clr,
  output logic [4:0]  height,
  output logic        game_over,
  output logic        win
);

  // All geometry arithmetic is done at 11 bits so sums never wrap.
  localparam logic [10:0] WID11    = 11'(WIDTH);
  localparam logic [10:0] HR11     = 11'(HEIGHT_RATIO);
  localparam logic [10:0] BASE11   = 11'(BASE_Y);
  localparam logic [10:0] XMAX11   = 11'(SCREEN_W - WIDTH);
  localparam logic [10:0] MSTEP11  = 11'(MOVE_STEP);
  localparam logic [10:0] FSTEP11  = 11'(FALL_STEP);
  localparam logic [9:0]  POS_INIT = 10'((SCREEN_W - WIDTH) / 2);
  localparam logic [3:0]  MISS_LIM = 4'(MAX_MISS);

  sky_state_e  state_q, state_d;
  logic [9:0]  pos_q, pos_d;
  logic [9:0]  fx_q, fx_d;
  logic [9:0]  fy_q, fy_d;
  logic [1:0]  clr_q, clr_d;
  logic [31:0] colors_q, colors_d;
  logic [4:0]  height_q, height_d;
  logic [3:0]  miss_q, miss_d;
  logic        over_q, over_d;
  logic        win_q, win_d;

  logic [11:0] rnd;
  logic [10:0] floor_y;
  logic [10:0] fall_step;
  logic [10:0] fy_adv;
  logic [10:0] pos_sum;
  logic [9:0]  pos_moved;
  logic [9:0]  spawn_x;
  logic [1:0]  spawn_clr;
  logic        hit;

  sky_lfsr u_lfsr (
    .clk_i  (dclk),
    .rst_ni (rst),
    .rnd_o  (rnd)
  );

  // Landing row for the current stack height.
  assign floor_y = BASE11 - ({6'b0, height_q} * HR11);

`ifdef SKY_SPEEDUP_EN
  assign fall_step = FSTEP11 + {8'b0, height_q[4:2]};
`else
  assign fall_step = FSTEP11;
`endif

  assign fy_adv = {1'b0, fy_q} + fall_step;

  // Out-of-range spawn columns fold back by 512 to stay on screen.
  assign spawn_x   = ({1'b0, rnd[9:0]} > XMAX11) ? (rnd[9:0] - 10'd512) : rnd[9:0];
  assign spawn_clr = (rnd[11:10] == 2'(CLR_NONE)) ? 2'(CLR_GREEN) : rnd[11:10];

  // Horizontal overlap between falling block and stack top.
  assign hit = (({1'b0, fx_q} + WID11) > {1'b0, pos_q}) &&
               (({1'b0, pos_q} + WID11) > {1'b0, fx_q});

  always_comb begin
    pos_sum   = {1'b0, pos_q} + MSTEP11;
    pos_moved = pos_q;
    if (move_l && !move_r) begin
      pos_moved = ({1'b0, pos_q} < MSTEP11) ? '0 : 10'({1'b0, pos_q} - MSTEP11);
    end else if (move_r && !move_l) begin
      pos_moved = (pos_sum > XMAX11) ? XMAX11[9:0] : pos_sum[9:0];
    end
  end

  always_comb begin
    state_d  = state_q;
    pos_d    = pos_q;
    fx_d     = fx_q;
    fy_d     = fy_q;
    clr_d    = clr_q;
    colors_d = colors_q;
    height_d = height_q;
    miss_d   = miss_q;
    over_d   = over_q;
    win_d    = win_q;

    if (start) begin
      // Restart beats a coincident tick: no motion this cycle.
      colors_d = '0;
      height_d = '0;
      miss_d   = '0;
      over_d   = 1'b0;
      win_d    = 1'b0;
      pos_d    = POS_INIT;
      state_d  = ST_SPAWN;
    end else begin
      unique case (state_q)
        ST_SPAWN: begin
          if (tick) pos_d = pos_moved;
          fx_d    = spawn_x;
          fy_d    = '0;
          clr_d   = spawn_clr;
          state_d = ST_FALL;
        end
        ST_FALL: begin
          if (tick) begin
            pos_d = pos_moved;
            if (fy_adv >= floor_y) begin
              fy_d    = floor_y[9:0];
              state_d = ST_LAND;
            end else begin
              fy_d = fy_adv[9:0];
            end
          end
        end
        ST_LAND: begin
          if (tick) pos_d = pos_moved;
          clr_d = '0;
          if (hit) begin
            colors_d[{height_q[3:0], 1'b0} +: 2] = clr_q;
            height_d = height_q + 5'd1;
            if (height_q == 5'd15) begin
              win_d   = 1'b1;
              state_d = ST_FULL;
            end else begin
              state_d = ST_SPAWN;
            end
          end else begin
            miss_d = miss_q + 4'd1;
            if ((miss_q + 4'd1) == MISS_LIM) begin
              over_d  = 1'b1;
              state_d = ST_OVER;
            end else begin
              state_d = ST_SPAWN;
            end
          end
        end
        ST_OVER, ST_FULL: begin
        end
        default: state_d = ST_SPAWN;
      endcase
    end
  end

  always_ff @(posedge dclk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_SPAWN;
      pos_q    <= POS_INIT;
      fx_q     <= '0;
      fy_q     <= '0;
      clr_q    <= '0;
      colors_q <= '0;
      height_q <= '0;
      miss_q   <= '0;
      over_q   <= 1'b0;
      win_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pos_q    <= pos_d;
      fx_q     <= fx_d;
      fy_q     <= fy_d;
      clr_q    <= clr_d;
      colors_q <= colors_d;
      height_q <= height_d;
      miss_q   <= miss_d;
      over_q   <= over_d;
      win_q    <= win_d;
    end
  end

  assign pos_x     = pos_q;
  assign colors    = colors_q;
  assign fall_x    = fx_q;
  assign fall_y    = fy_q;
  assign fall_clr  = clr_q;
  assign height    = height_q;
  assign game_over = over_q;
  assign win       = win_q;

endmodule

// File: doc/block_drop_ctrl.md
# block_drop_ctrl

Game-state engine for the stacking game. Sits directly upstream of the VGA draw stage and generates everything it renders: the player's stack position, the 16-slot packed stack colour word, and the falling block's position and colour. It spawns pseudo-random blocks, advances them once per frame, resolves catch or miss on landing, and tracks height, misses and end-of-game.

## Interface
Parameters:
- WIDTH, 100, block and stack width in pixels
- HEIGHT_RATIO, 20, block height in pixels
- BASE_Y, 400, top y of stack slot 0
- SCREEN_W, 640, visible width
- MOVE_STEP, 4, stack x pixels per frame
- FALL_STEP, 2, falling-block y pixels per frame
- MAX_MISS, 3, misses before game over

Ports:
- dclk  in  1  pixel clock, single clock domain
- rst  in  1  asynchronous, active-low reset
- tick  in  1  one-cycle frame strobe, asserted at the start of vertical blank
- move_l, move_r  in  1 each  level-sensitive, synchronised player buttons
- start  in  1  one-cycle restart pulse
- pos_x  out  10  stack left x
- colors  out  32  slot i is colors[2i+1:2i]; 00 empty, 01 green, 10 blue, 11 red
- fall_x, fall_y  out  10 each  falling block top-left corner
- fall_clr  out  2  falling block colour; 00 means no block is drawn
- height  out  5  occupied slots, 0..16
- game_over, win  out  1 each  sticky end-of-game flags

## Operation
- States: SPAWN, FALL, LAND, OVER, FULL. Reset enters SPAWN.
- SPAWN (1 cycle):
  - fall_y=0.
  - fall_x=lfsr[9:0]; if that value exceeds SCREEN_W-WIDTH (540), subtract 512.
  - fall_clr=lfsr[11:10]; remap 00 to 01.
  - Go to FALL.
- FALL, on each tick:
  - fall_y += step, where step is FALL_STEP, or the value defined in Configuration.
  - Land when the new fall_y >= BASE_Y - height*HEIGHT_RATIO. Then snap fall_y to exactly that value and go to LAND.
- LAND (1 cycle):
  - Catch when fall_x+WIDTH > pos_x && pos_x+WIDTH > fall_x. Use 11-bit compare.
  - On catch: write fall_clr into slot `height` and increment height. If height becomes 16, set win and go to FULL; otherwise go to SPAWN.
  - On miss: increment the miss counter. If it reaches MAX_MISS, set game_over and go to OVER; otherwise go to SPAWN.
  - fall_clr=00 on exit.
- pos_x movement: on every tick in SPAWN, FALL or LAND.
  - move_l only: subtract MOVE_STEP, clamp at 0.
  - move_r only: add MOVE_STEP, clamp at SCREEN_W-WIDTH.
  - Both or neither: hold.
- OVER/FULL: all outputs frozen. fall_clr=00. Ticks and buttons are ignored.
- start, in any state: clear colors, height, misses, game_over and win; set pos_x=270; go to SPAWN on the next cycle. The LFSR is not reset.
- LFSR: 16-bit Galois, polynomial x^16+x^14+x^13+x^11, seed 16'hACE1, advances every dclk cycle.

## Timing
- All outputs are registered. Values only change on the dclk edge that samples tick, in LAND, in SPAWN, or on start. They are therefore stable across each visible frame except for the single-cycle SPAWN and LAND updates.
- Reset values:
  - pos_x=270.
  - colors, fall_x, fall_y, fall_clr, height, game_over and win all 0.
  - Miss counter 0.
- Latency from landing tick to colors/height update: 1 cycle (LAND). Latency to the new block appearing: 2 cycles.
- A tick coinciding with SPAWN or LAND still moves pos_x. The fall step for that frame is dropped.
- start coinciding with tick: start wins, and no motion is applied.
- Slots at index >= height always read 00.

## Configuration
- SKY_SPEEDUP_EN defined: step = FALL_STEP + height[4:2], so speed rises by 1 px/frame every 4 stacked blocks (2..6).
- SKY_SPEEDUP_EN undefined: step = FALL_STEP constant.

## Structure
- Shared package sky_pkg holds:
  - the state encoding;
  - colour codes CLR_NONE/GREEN/BLUE/RED;
  - default geometry constants (WIDTH, HEIGHT_RATIO, BASE_Y, SCREEN_W), also used by the draw stage.
- One sub-module, sky_lfsr: free-running 16-bit LFSR with async active-low reset.

## Test plan
- Reset released, no tick → pos_x=270, colors=0, height=0. After 1 cycle: fall_clr≠00, fall_y=0, fall_x≤540.
- Force fall_x=270, 200 ticks with no buttons → block lands at fall_y=400, colors[1:0]=that fall_clr, height=1, next block spawned at fall_y=0.
- Hold move_l 100 ticks from pos_x=270 → pos_x clamps at 0. Hold move_r → pos_x clamps at 540. Both held → pos_x unchanged.
- pos_x=0, force fall_x=440 → miss: colors unchanged, misses+1. Third miss → game_over=1, fall_clr=00, outputs frozen under further ticks.
- 16 consecutive catches → height=16, win=1, all 16 slots nonzero. Then start → everything cleared, pos_x=270, new spawn.
- With SKY_SPEEDUP_EN, height=8 → fall_y advances 4 per tick. Without the macro → 2 per tick.
